ula_op_sequencer: RTL and testbench
===================================

# ula_op_sequencer

Controller that runs ALU/comparison operations on the stack machine's operand/ALU block. It accepts one opcode at a time over a valid/ready handshake, pops the needed operands from the data stack into the operand registers, and holds the ALU select stable for the whole operation. It then issues exactly one write-back pulse: a result push, a compare-stack write, or none for an illegal opcode or stack underflow. It sits between the instruction decoder and the ALU-operations block, and owns every control strobe of that block.

## Interface
Parameters:
- ADDR_WIDTH, 12, width of the stack depth count (stack holds up to 2^ADDR_WIDTH entries)
- CNT_WIDTH, 16, width of the completed-operation counter

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- OP_VALID  in  1  decoder presents an opcode
- OP_CODE  in  4  ALU opcode; same encoding as SEL_ULA
- OP_READY  out  1  sequencer can accept an opcode
- STACK_COUNT  in  ADDR_WIDTH+1  current number of entries on the data stack
- STACK_POP  out  1  pop pulse; TOS decrements at the end of this cycle
- STACK_PUSH  out  1  push ALU result pulse; stack writes ULA_OUT at the end of this cycle
- CTRL_REG_OP1  out  1  load operand register 1 (ULA_IN_1) from REG_IN
- CTRL_REG_OP2  out  1  load operand register 2 (ULA_IN_2) from REG_IN
- CTRL_REG_OVERFLOW  out  1  capture the overflow flag
- CTRL_STACK_COMP  out  1  write the comparison bit into the compare stack
- SEL_ULA  out  4  ALU function select
- OP_DONE  out  1  one-cycle pulse: operation completed normally
- OP_ERR  out  1  one-cycle pulse: illegal opcode or underflow
- OP_COUNT  out  CNT_WIDTH  number of normally completed operations, wraps modulo 2^CNT_WIDTH

## Operation
- Opcode classes:
  - ARITH: 0000 to 0100 (add, sub, mult, lshift, rshift).
  - LOGIC2: 0101 to 0111 (or, and, xor).
  - UNARY: 1000 (not). Needs only operand 1.
  - COMP: 1001 to 1110.
  - ILLEGAL: 1111.
- Operands needed: 1 for UNARY, 2 for all other legal classes.
- Operand order:
  - First pop takes TOS into CTRL_REG_OP1 (ULA_IN_1).
  - Second pop takes TOS-1 into CTRL_REG_OP2 (ULA_IN_2).
  - Therefore SUB computes (TOS-1) - TOS.
- Stack read is asynchronous. REG_IN shows the TOS data in the same cycle as STACK_POP, so a CTRL_REG_OPx pulse always coincides with its STACK_POP pulse.
- All outputs are registered (Moore). There is no combinational path from any input to any output except OP_READY, which equals (state==IDLE).
- States:
  - **IDLE**:
    - OP_READY=1 and SEL_ULA=4'b1111 (the ALU is inert).
    - On OP_VALID, the opcode is accepted and latched into SEL_ULA for the whole operation.
    - If the opcode is ILLEGAL, or STACK_COUNT is below the operands needed, go to ERR.
    - Otherwise go to LOAD1.
  - **LOAD1**:
    - STACK_POP=1 and CTRL_REG_OP1=1.
    - Next state is EXEC for UNARY, otherwise LOAD2.
  - **LOAD2**:
    - STACK_POP=1 and CTRL_REG_OP2=1.
    - Next state is EXEC.
  - **EXEC**: OP_DONE=1 and OP_COUNT increments at the end of the cycle. Strobes by class:
    - ARITH: STACK_PUSH=1 and CTRL_REG_OVERFLOW=1.
    - LOGIC2 and UNARY: STACK_PUSH=1 only.
    - COMP: CTRL_STACK_COMP=1 only, with no push.
    - Next state is IDLE.
  - **ERR**:
    - OP_ERR=1.
    - No pop, push or control strobe; OP_COUNT is unchanged.
    - Next state is IDLE.
- SEL_ULA stays at the accepted opcode from LOAD1 (or ERR) through EXEC, then returns to 4'b1111 in IDLE.
- At most one of STACK_PUSH, CTRL_STACK_COMP, OP_ERR is high in any cycle. STACK_POP and STACK_PUSH are never high together.
- STACK_COUNT is sampled only at acceptance, so the underflow check is exact and no pop ever occurs on an empty stack.

## Timing
- Reset value of every output:
  - OP_READY=1 and SEL_ULA=4'b1111.
  - OP_COUNT=0.
  - All other outputs 0.
- Reset asserted mid-operation: go immediately to IDLE. Remaining pops and the write-back are abandoned and OP_COUNT is not incremented. Operand registers outside this block are left as they are.
- Latency, counted from the accept edge E0:
  - Binary op: LOAD1 in cycle 1, LOAD2 in cycle 2, EXEC/OP_DONE in cycle 3, OP_READY back in cycle 4. Throughput is 1 op per 4 cycles.
  - Unary op: OP_DONE in cycle 2, OP_READY in cycle 3.
  - Error: OP_ERR in cycle 1, OP_READY in cycle 2.
- OP_VALID while OP_READY=0 is ignored. The decoder must hold OP_VALID and OP_CODE until it samples OP_READY=1 at an edge.
- OP_COUNT wraps from 2^CNT_WIDTH-1 to 0.

## Test plan
- ADD with stack [.., 200, 100] (TOS=100), count 2:
  - Pops happen in cycles 1-2 with OP1 and OP2 loads.
  - In cycle 3, SEL_ULA=0000, STACK_PUSH=1, CTRL_REG_OVERFLOW=1 (ALU result 44, overflow 1), OP_DONE=1.
  - OP_COUNT becomes 1.
- SUB with TOS=3, TOS-1=10: CTRL_REG_OP1 with REG_IN=3, then CTRL_REG_OP2 with REG_IN=10, SEL_ULA=0001 steady for 3 cycles, push of 7.
- NOT (1000) with count 1: exactly one pop; OP_DONE in cycle 2; STACK_PUSH=1; CTRL_REG_OVERFLOW=0.
- COMP 1011 (greater) with operands 5, 9: CTRL_STACK_COMP=1 in EXEC, no STACK_PUSH, OP_DONE=1.
- Errors produce OP_ERR in cycle 1, no pops, and OP_COUNT unchanged:
  - Opcode 1111 with count 5.
  - ADD with count 1.
- Reset asserted during LOAD2:
  - All outputs return to reset values asynchronously.
  - No OP_DONE.
  - The next ADD completes normally with OP_COUNT=1.
- 65536 back-to-back ADDs with count kept at 2 or more: OP_COUNT wraps to 0; successive OP_DONE pulses are exactly 4 cycles apart.

Source files
------------

// File: rtl/ula_op_sequencer.sv
// ula_op_sequencer: accepts one ALU opcode at a time, pops its operands from the
// data stack into the operand registers, holds the ALU select for the whole
// operation and issues exactly one write-back strobe (push, compare write or error).
module ula_op_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  OP_VALID,
  input  logic [3:0]            OP_CODE,
  output logic                  OP_READY,
  input  logic [ADDR_WIDTH:0]   STACK_COUNT,
  output logic                  STACK_POP,
  output logic                  STACK_PUSH,
  output logic                  CTRL_REG_OP1,
  output logic                  CTRL_REG_OP2,
  output logic                  CTRL_REG_OVERFLOW,
  output logic                  CTRL_STACK_COMP,
  output logic [3:0]            SEL_ULA,
  output logic                  OP_DONE,
  output logic                  OP_ERR,
  output logic [CNT_WIDTH-1:0]  OP_COUNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD1 = 3'd1,
    S_LOAD2 = 3'd2,
    S_EXEC  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [3:0]          SEL_INERT = 4'b1111;
  localparam logic [ADDR_WIDTH:0] CNT_ZERO  = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0] CNT_TWO   = (ADDR_WIDTH+1)'(2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  // Opcode class decoders
  function automatic logic f_is_arith(input logic [3:0] op);
    return (op <= 4'd4);
  endfunction

  function automatic logic f_is_unary(input logic [3:0] op);
    return (op == 4'd8);
  endfunction

  function automatic logic f_is_comp(input logic [3:0] op);
    return (op >= 4'd9) && (op <= 4'd14);
  endfunction

  function automatic logic f_is_illegal(input logic [3:0] op);
    return (op == 4'd15);
  endfunction

  state_t                 r_state;
  logic [3:0]             r_sel;
  logic                   r_pop;
  logic                   r_push;
  logic                   r_op1;
  logic                   r_op2;
  logic                   r_ovf;
  logic                   r_comp;
  logic                   r_done;
  logic                   r_err;
  logic [CNT_WIDTH-1:0]   r_count;

  logic                   w_underflow;
  logic                   w_exec_push;
  logic                   w_exec_ovf;
  logic                   w_exec_comp;

  // Underflow test on the incoming opcode, and EXEC strobes for the latched opcode
  always_comb begin
    w_underflow = 1'b0;
    if (f_is_unary(OP_CODE)) begin
      w_underflow = (STACK_COUNT == CNT_ZERO);
    end else begin
      w_underflow = (STACK_COUNT < CNT_TWO);
    end
    w_exec_push = !f_is_comp(r_sel);
    w_exec_ovf  = f_is_arith(r_sel);
    w_exec_comp = f_is_comp(r_sel);
  end

  // Sequencer FSM with registered strobes; pulses default low every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sel   <= SEL_INERT;
      r_pop   <= 1'b0;
      r_push  <= 1'b0;
      r_op1   <= 1'b0;
      r_op2   <= 1'b0;
      r_ovf   <= 1'b0;
      r_comp  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_count <= {CNT_WIDTH{1'b0}};
    end else begin
      r_pop  <= 1'b0;
      r_push <= 1'b0;
      r_op1  <= 1'b0;
      r_op2  <= 1'b0;
      r_ovf  <= 1'b0;
      r_comp <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (OP_VALID) begin
            r_sel <= OP_CODE;
            if (f_is_illegal(OP_CODE) || w_underflow) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state <= S_LOAD1;
              r_pop   <= 1'b1;
              r_op1   <= 1'b1;
            end
          end else begin
            r_sel <= SEL_INERT;
          end
        end
        S_LOAD1: begin
          if (f_is_unary(r_sel)) begin
            r_state <= S_EXEC;
            r_push  <= w_exec_push;
            r_ovf   <= w_exec_ovf;
            r_comp  <= w_exec_comp;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_LOAD2;
            r_pop   <= 1'b1;
            r_op2   <= 1'b1;
          end
        end
        S_LOAD2: begin
          r_state <= S_EXEC;
          r_push  <= w_exec_push;
          r_ovf   <= w_exec_ovf;
          r_comp  <= w_exec_comp;
          r_done  <= 1'b1;
        end
        S_EXEC: begin
          r_state <= S_IDLE;
          r_sel   <= SEL_INERT;
          r_count <= r_count + CNT_ONE;
        end
        S_ERR: begin
          r_state <= S_IDLE;
          r_sel   <= SEL_INERT;
        end
        default: begin
          r_state <= S_IDLE;
          r_sel   <= SEL_INERT;
        end
      endcase
    end
  end

  assign OP_READY          = (r_state == S_IDLE);
  assign STACK_POP         = r_pop;
  assign STACK_PUSH        = r_push;
  assign CTRL_REG_OP1      = r_op1;
  assign CTRL_REG_OP2      = r_op2;
  assign CTRL_REG_OVERFLOW = r_ovf;
  assign CTRL_STACK_COMP   = r_comp;
  assign SEL_ULA           = r_sel;
  assign OP_DONE           = r_done;
  assign OP_ERR            = r_err;
  assign OP_COUNT          = r_count;

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Testbench for ula_op_sequencer: directed scenarios against a small stack/ALU model.
module tb_ula_op_sequencer;

  localparam int AW = 12;
  localparam int CW = 8;

  // Strobe vector: {READY, POP, PUSH, OP1, OP2, OVF, COMP, DONE, ERR}
  localparam logic [8:0] V_IDLE  = 9'b100000000;
  localparam logic [8:0] V_LOAD1 = 9'b010100000;
  localparam logic [8:0] V_LOAD2 = 9'b010010000;
  localparam logic [8:0] V_EXA   = 9'b001001010;
  localparam logic [8:0] V_EXL   = 9'b001000010;
  localparam logic [8:0] V_EXC   = 9'b000000110;
  localparam logic [8:0] V_ERR   = 9'b000000001;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          OP_VALID = 1'b0;
  logic [3:0]    OP_CODE = 4'd0;
  logic          OP_READY;
  logic [AW:0]   STACK_COUNT;
  logic          STACK_POP, STACK_PUSH, CTRL_REG_OP1, CTRL_REG_OP2;
  logic          CTRL_REG_OVERFLOW, CTRL_STACK_COMP, OP_DONE, OP_ERR;
  logic [3:0]    SEL_ULA;
  logic [CW-1:0] OP_COUNT;

  int errors = 0;
  int checks = 0;

  // Stack / ALU model
  logic [7:0] stk [0:15];
  logic [3:0] sp = 4'd0;
  logic [7:0] in1 = 8'd0;
  logic [7:0] in2 = 8'd0;
  logic [7:0] alu_out;
  logic       ld_req = 1'b0;
  logic [7:0] ld_a = 8'd0;
  logic [7:0] ld_b = 8'd0;
  logic [3:0] ld_n = 4'd0;
  logic       bb_mode = 1'b0;
  wire  [7:0] top = stk[sp - 4'd1];
  wire  [8:0] strobes = {OP_READY, STACK_POP, STACK_PUSH, CTRL_REG_OP1, CTRL_REG_OP2,
                         CTRL_REG_OVERFLOW, CTRL_STACK_COMP, OP_DONE, OP_ERR};

  assign STACK_COUNT = {9'd0, sp};

  always #5 clk = ~clk;

  ula_op_sequencer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .OP_VALID(OP_VALID), .OP_CODE(OP_CODE), .OP_READY(OP_READY),
    .STACK_COUNT(STACK_COUNT), .STACK_POP(STACK_POP), .STACK_PUSH(STACK_PUSH),
    .CTRL_REG_OP1(CTRL_REG_OP1), .CTRL_REG_OP2(CTRL_REG_OP2),
    .CTRL_REG_OVERFLOW(CTRL_REG_OVERFLOW), .CTRL_STACK_COMP(CTRL_STACK_COMP),
    .SEL_ULA(SEL_ULA), .OP_DONE(OP_DONE), .OP_ERR(OP_ERR), .OP_COUNT(OP_COUNT)
  );

  // 8-bit ALU model: SUB is (TOS-1) - TOS = in2 - in1
  always_comb begin
    case (SEL_ULA)
      4'd0:    alu_out = in1 + in2;
      4'd1:    alu_out = in2 - in1;
      4'd8:    alu_out = ~in1;
      default: alu_out = 8'h00;
    endcase
  end

  // Stack model: asynchronous read of TOS, pop/push at the clock edge
  always @(posedge clk) begin
    if (ld_req) begin
      stk[0] <= ld_a;
      stk[1] <= ld_b;
      sp     <= ld_n;
    end else begin
      if (CTRL_REG_OP1) in1 <= stk[sp - 4'd1];
      if (CTRL_REG_OP2) in2 <= stk[sp - 4'd1];
      if (STACK_POP && !bb_mode) sp <= sp - 4'd1;
      else if (STACK_PUSH && !bb_mode) begin
        stk[sp] <= alu_out;
        sp      <= sp + 4'd1;
      end
    end
  end

  task automatic preload(input logic [7:0] a, input logic [7:0] b, input logic [3:0] n);
    @(negedge clk);
    ld_a = a; ld_b = b; ld_n = n; ld_req = 1'b1;
    @(negedge clk);
    ld_req = 1'b0;
  endtask

  // Present an opcode for one edge; returns at the negedge of cycle 1
  task automatic issue(input logic [3:0] code);
    @(negedge clk);
    OP_VALID = 1'b1; OP_CODE = code;
    @(negedge clk);
    OP_VALID = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (strobes !== V_IDLE) begin errors++; $display("FAIL reset_strobes got=%b exp=%b", strobes, V_IDLE); end
    checks++; if (SEL_ULA !== 4'b1111) begin errors++; $display("FAIL reset_sel got=%h exp=f", SEL_ULA); end
    checks++; if (OP_COUNT !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", OP_COUNT); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    preload(8'd200, 8'd100, 4'd2);
    issue(4'd0);
    checks++; if (strobes !== V_LOAD1 || SEL_ULA !== 4'd0) begin errors++; $display("FAIL add_c1 got=%b/%h exp=%b/0", strobes, SEL_ULA, V_LOAD1); end
    @(negedge clk);
    checks++; if (strobes !== V_LOAD2 || SEL_ULA !== 4'd0) begin errors++; $display("FAIL add_c2 got=%b/%h exp=%b/0", strobes, SEL_ULA, V_LOAD2); end
    @(negedge clk);
    checks++; if (strobes !== V_EXA || SEL_ULA !== 4'd0) begin errors++; $display("FAIL add_c3 got=%b/%h exp=%b/0", strobes, SEL_ULA, V_EXA); end
    checks++; if (alu_out !== 8'd44) begin errors++; $display("FAIL add_alu got=%0d exp=44", alu_out); end
    @(negedge clk);
    checks++; if (strobes !== V_IDLE || SEL_ULA !== 4'b1111) begin errors++; $display("FAIL add_c4 got=%b/%h exp=%b/f", strobes, SEL_ULA, V_IDLE); end
    checks++; if (OP_COUNT !== 8'd1) begin errors++; $display("FAIL add_count got=%0d exp=1", OP_COUNT); end
    checks++; if (sp !== 4'd1 || top !== 8'd44) begin errors++; $display("FAIL add_stack got=%0d/%0d exp=1/44", sp, top); end
  endtask

  task automatic test_sub();
    preload(8'd10, 8'd3, 4'd2);
    issue(4'd1);
    checks++; if (strobes !== V_LOAD1 || top !== 8'd3 || SEL_ULA !== 4'd1) begin errors++; $display("FAIL sub_c1 got=%b/%0d/%h exp=%b/3/1", strobes, top, SEL_ULA, V_LOAD1); end
    @(negedge clk);
    checks++; if (strobes !== V_LOAD2 || top !== 8'd10 || SEL_ULA !== 4'd1) begin errors++; $display("FAIL sub_c2 got=%b/%0d/%h exp=%b/10/1", strobes, top, SEL_ULA, V_LOAD2); end
    @(negedge clk);
    checks++; if (strobes !== V_EXA || SEL_ULA !== 4'd1) begin errors++; $display("FAIL sub_c3 got=%b/%h exp=%b/1", strobes, SEL_ULA, V_EXA); end
    @(negedge clk);
    checks++; if (sp !== 4'd1 || top !== 8'd7) begin errors++; $display("FAIL sub_result got=%0d/%0d exp=1/7", sp, top); end
    checks++; if (OP_COUNT !== 8'd2) begin errors++; $display("FAIL sub_count got=%0d exp=2", OP_COUNT); end
  endtask

  task automatic test_not();
    preload(8'h0F, 8'h00, 4'd1);
    issue(4'd8);
    checks++; if (strobes !== V_LOAD1 || SEL_ULA !== 4'd8) begin errors++; $display("FAIL not_c1 got=%b/%h exp=%b/8", strobes, SEL_ULA, V_LOAD1); end
    @(negedge clk);
    checks++; if (strobes !== V_EXL || SEL_ULA !== 4'd8) begin errors++; $display("FAIL not_c2 got=%b/%h exp=%b/8", strobes, SEL_ULA, V_EXL); end
    @(negedge clk);
    checks++; if (strobes !== V_IDLE) begin errors++; $display("FAIL not_c3 got=%b exp=%b", strobes, V_IDLE); end
    checks++; if (sp !== 4'd1 || top !== 8'hF0) begin errors++; $display("FAIL not_result got=%0d/%h exp=1/f0", sp, top); end
    checks++; if (OP_COUNT !== 8'd3) begin errors++; $display("FAIL not_count got=%0d exp=3", OP_COUNT); end
  endtask

  task automatic test_comp();
    preload(8'd9, 8'd5, 4'd2);
    issue(4'b1011);
    checks++; if (strobes !== V_LOAD1) begin errors++; $display("FAIL comp_c1 got=%b exp=%b", strobes, V_LOAD1); end
    @(negedge clk);
    checks++; if (strobes !== V_LOAD2) begin errors++; $display("FAIL comp_c2 got=%b exp=%b", strobes, V_LOAD2); end
    @(negedge clk);
    checks++; if (strobes !== V_EXC || SEL_ULA !== 4'b1011) begin errors++; $display("FAIL comp_c3 got=%b/%h exp=%b/b", strobes, SEL_ULA, V_EXC); end
    checks++; if (in1 !== 8'd5 || in2 !== 8'd9) begin errors++; $display("FAIL comp_operands got=%0d,%0d exp=5,9", in1, in2); end
    @(negedge clk);
    checks++; if (sp !== 4'd0 || OP_COUNT !== 8'd4) begin errors++; $display("FAIL comp_after got=%0d/%0d exp=0/4", sp, OP_COUNT); end
  endtask

  task automatic test_errors();
    preload(8'd1, 8'd2, 4'd5);
    issue(4'b1111);
    checks++; if (strobes !== V_ERR || SEL_ULA !== 4'b1111) begin errors++; $display("FAIL ill_c1 got=%b/%h exp=%b/f", strobes, SEL_ULA, V_ERR); end
    @(negedge clk);
    checks++; if (strobes !== V_IDLE || sp !== 4'd5 || OP_COUNT !== 8'd4) begin errors++; $display("FAIL ill_after got=%b/%0d/%0d exp=%b/5/4", strobes, sp, OP_COUNT, V_IDLE); end
    preload(8'd7, 8'd0, 4'd1);
    issue(4'd0);
    checks++; if (strobes !== V_ERR || SEL_ULA !== 4'd0) begin errors++; $display("FAIL unf_c1 got=%b/%h exp=%b/0", strobes, SEL_ULA, V_ERR); end
    @(negedge clk);
    checks++; if (strobes !== V_IDLE || SEL_ULA !== 4'b1111 || sp !== 4'd1 || OP_COUNT !== 8'd4) begin errors++; $display("FAIL unf_after got=%b/%h/%0d/%0d exp=%b/f/1/4", strobes, SEL_ULA, sp, OP_COUNT, V_IDLE); end
  endtask

  task automatic test_reset_mid_op();
    int done_seen;
    preload(8'd1, 8'd2, 4'd2);
    issue(4'd0);
    @(negedge clk);
    checks++; if (strobes !== V_LOAD2) begin errors++; $display("FAIL rmid_load2 got=%b exp=%b", strobes, V_LOAD2); end
    rst = 1'b1;
    #1;
    checks++; if (strobes !== V_IDLE || SEL_ULA !== 4'b1111 || OP_COUNT !== 8'd0) begin errors++; $display("FAIL rmid_async got=%b/%h/%0d exp=%b/f/0", strobes, SEL_ULA, OP_COUNT, V_IDLE); end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (OP_DONE) done_seen++;
    end
    checks++; if (done_seen !== 0) begin errors++; $display("FAIL rmid_nodone got=%0d exp=0", done_seen); end
    preload(8'd20, 8'd22, 4'd2);
    issue(4'd0);
    repeat (3) @(negedge clk);
    checks++; if (OP_COUNT !== 8'd1 || top !== 8'd42) begin errors++; $display("FAIL rmid_next got=%0d/%0d exp=1/42", OP_COUNT, top); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int last;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    preload(8'd1, 8'd1, 4'd2);
    bb_mode = 1'b1;
    OP_VALID = 1'b1; OP_CODE = 4'd0;
    ndone = 0;
    last = 0;
    for (int cyc = 0; cyc < 1100 && ndone < 256; cyc++) begin
      @(negedge clk);
      if (OP_DONE) begin
        if (ndone > 0) begin
          checks++; if (cyc - last !== 4) begin errors++; $display("FAIL b2b_gap got=%0d exp=4 at op %0d", cyc - last, ndone); end
        end
        checks++; if (OP_COUNT !== CW'(ndone)) begin errors++; $display("FAIL b2b_count got=%0d exp=%0d", OP_COUNT, ndone); end
        last = cyc;
        ndone++;
      end
    end
    OP_VALID = 1'b0;
    checks++; if (ndone !== 256) begin errors++; $display("FAIL b2b_timeout got=%0d exp=256", ndone); end
    @(negedge clk);
    checks++; if (OP_COUNT !== 8'd0) begin errors++; $display("FAIL b2b_wrap got=%0d exp=0", OP_COUNT); end
    bb_mode = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_not();
    test_comp();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
